instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream fetch stage of the single-cycle RV32I core: owns the PC, issues in-order requests
//  to instruction memory, buffers returned words, and presents instr/PC to decode.
//  Decode slices op/funct3/funct7[5] from dec_instr for the control unit.
//  PCSrc/PCTarget from execute arrive as a redirect: flush wrong-path work, restart fetch.
// PARAMETERS
//  XLEN      32     address/instruction width
//  RESET_PC  32'h0  first fetch address after reset
//  BUF_DEPTH 2      instruction buffer entries; also max outstanding requests (power of 2, >=2)
// PORTS
//  clk            in   1     single clock, rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  imem_req_valid out  1     request valid
//  imem_req_ready in   1     memory accepts request this cycle
//  imem_req_addr  out  XLEN  word-aligned fetch address
//  imem_rsp_valid in   1     response valid (in order, >=1 cycle after accept, no backpressure)
//  imem_rsp_data  in   XLEN  instruction word
//  redirect_valid in   1     taken branch/jump (PCSrc)
//  redirect_pc    in   XLEN  target (PCTarget); bits[1:0] forced to 0
//  dec_valid      out  1     instruction available to decode
//  dec_ready      in   1     decode consumes this cycle
//  dec_instr      out  XLEN  instruction word
//  dec_pc         out  XLEN  its address
//  dec_pc_plus4   out  XLEN  dec_pc + 4 (mod 2^XLEN)
// BEHAVIOUR
//  Reset (async assert, sync release): fetch_pc=RESET_PC, buffer empty, outstanding=0,
//   discard=0, state=S_BOOT, imem_req_valid=0, dec_valid=0, dec_* data = 0.
//  FSM: S_BOOT -> S_RUN after one clock. S_RUN -> S_FLUSH on redirect while discard_next>0.
//   S_FLUSH -> S_RUN when discard reaches 0. No requests are issued in S_BOOT or S_FLUSH.
//  Issue (S_RUN only): imem_req_valid=1 when outstanding+occupancy < BUF_DEPTH and no redirect
//   this cycle. Address = fetch_pc. On valid&ready: fetch_pc += 4 (wraps FFFF_FFFC -> 0),
//   and a pc tag is pushed to an internal FIFO matching responses. Address is held while
//   stalled (valid & !ready); no combinational path from imem_req_ready to imem_req_valid.
//  Response: if discard>0, drop and decrement discard. Otherwise write {data,pc} to buffer;
//   the credit rule guarantees the buffer is never full at a response (overflow = assertion).
//  Decode: dec_valid = buffer not empty; dec_* driven from head register (registered
//   outputs, 0-cycle mux from head). Pop on dec_valid & dec_ready.
//   Min latency: request accepted at cycle N, response at N+1, dec_valid at N+2.
//  Redirect (any state, highest priority):
//   - Buffer flushed next cycle. A same-cycle dec handshake still completes.
//   - fetch_pc <= {redirect_pc[31:2],2'b00}; imem_req_valid forced 0 that cycle.
//   - discard <= discard + outstanding (incl. same-cycle accepted request) - same-cycle
//     response; a same-cycle response is always dropped.
//   - Redirect during S_FLUSH retargets the PC and accumulates discard.
//  Simultaneous push and pop keep occupancy unchanged. Buffer pointers wrap mod BUF_DEPTH.
//  Reset mid-transaction: all state cleared at once. Memory must also be reset; late
//   responses after reset are a protocol error.
// STRUCTURE
//  Shared package fetch_pkg: RESET_PC default, fetch state enum (S_BOOT/S_RUN/S_FLUSH),
//   typedef fetch_entry_t {instr[31:0], pc[31:0]}, localparam INSTR_BYTES=4.
//  One sub-module: fetch_fifo (parameterised sync FIFO, async active-low reset, flush input,
//   push/pop/full/empty/count) instantiated for the instruction buffer.
//  Counters outstanding/discard are $clog2(BUF_DEPTH)+1 bits wide.
// TESTING
//  1 Reset release, 1-cycle memory, dec_ready=1 -> addresses 0,4,8,C; dec_pc 0,4,8 in order,
//    first dec_valid 3 cycles after reset release, dec_pc_plus4 = dec_pc+4.
//  2 dec_ready=0 for 10 cycles -> exactly 2 requests issued, buffer holds 0,4; no drop after release.
//  3 Two requests outstanding (latency 3), redirect_pc=0x100 -> both responses dropped,
//    S_FLUSH until drained, next request addr 0x100, first dec_pc 0x100.
//  4 Redirect same cycle as response and dec handshake at pc 0x8 -> 0x8 consumed, response
//    dropped, buffer empty next cycle.
//  5 RESET_PC=0xFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; redirect_pc=0x203
//    -> fetch 0x200.
//  6 imem_req_ready=0 for 5 cycles -> addr stable, valid held; rst_n low mid-stall ->
//    all outputs 0 immediately, refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INSTR_BYTES      : PC increment per sequential instruction
//   fetch_state_t    : fetch controller states
//   fetch_entry_t    : one buffered instruction word with the address it came from
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush input.
//   clk, rst_n       : clock, asynchronous active-low reset (pointers/count only)
//   flush            : empties the FIFO at the next edge; wins over push/pop
//   push, push_data  : write one entry (ignored when full)
//   pop              : drop the head entry (ignored when empty)
//   head             : current head entry, valid while !empty
//   full, empty      : occupancy flags
//   count            : number of stored entries (0..DEPTH)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !flush));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order instruction memory requests,
// buffers returned words and presents them to decode.
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_req_valid/ready    : request handshake, imem_req_addr = word address
//   imem_rsp_valid/data     : in-order responses, no backpressure
//   redirect_valid/pc       : taken branch/jump; flushes wrong-path work
//   dec_valid/ready         : decode handshake
//   dec_instr/pc/pc_plus4   : instruction at buffer head, its PC and PC+4
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_plus4
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   discard, discard_next;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   buf_count;
  logic            req_fire, rsp_drop, rsp_keep, dec_fire;
  logic            buf_full, buf_empty, tag_full, tag_empty;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    buf_push, buf_head;

  // The tag FIFO holds the PC of every live (not-to-be-discarded) request,
  // so its occupancy is exactly the outstanding-request count.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_instr_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (buf_push),
    .pop       (dec_fire),
    .head      (buf_head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  // Credit: a request is only issued if its word is guaranteed a buffer slot.
  // Depends on registered state and redirect only, never on imem_req_ready.
  assign imem_req_valid = (state == S_RUN) && !redirect_valid &&
                          ((int'(outstanding) + int'(buf_count)) < BUF_DEPTH);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response arriving with a redirect belongs to the wrong path as well.
  assign rsp_drop       = imem_rsp_valid & (redirect_valid | (discard != '0));
  assign rsp_keep       = imem_rsp_valid & ~rsp_drop;
  assign buf_push.instr = imem_rsp_data;
  assign buf_push.pc    = tag_head;

  assign dec_valid      = !buf_empty;
  assign dec_fire       = dec_valid & dec_ready;
  assign dec_instr      = dec_valid ? buf_head.instr : '0;
  assign dec_pc         = dec_valid ? buf_head.pc : '0;
  assign dec_pc_plus4   = dec_valid ? buf_head.pc + XLEN'(INSTR_BYTES) : '0;

  always_comb begin
    discard_next = discard;
    if (redirect_valid)
      discard_next = discard + outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    else if (rsp_drop)
      discard_next = discard - CW'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   if (redirect_valid && discard_next != '0) state_next = S_FLUSH;
      S_FLUSH: if (discard_next == '0) state_next = S_RUN;
      default: state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      discard  <= '0;
      fetch_pc <= RESET_PC;
    end else begin
      state   <= state_next;
      discard <= discard_next;
      if (redirect_valid)
        fetch_pc <= redirect_pc & ~XLEN'(INSTR_BYTES - 1);
      else if (req_fire)
        fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
    end
  end

  a_buf_room:  assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && buf_full));
  a_tag_match: assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && tag_empty));
  a_tag_room:  assert property (@(posedge clk) disable iff (!rst_n) !(req_fire && tag_full));

endmodule
